// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: access-size codes, burst lengths,
// FSM states and requester port IDs.
package mem_pkg;

    localparam logic [1:0] SIZE_1W  = 2'b00;
    localparam logic [1:0] SIZE_4W  = 2'b01;
    localparam logic [1:0] SIZE_8W  = 2'b10;
    localparam logic [1:0] SIZE_16W = 2'b11;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_LAST  = 2'b10
    } arb_state_e;

    function automatic logic [4:0] burst_len(input logic [1:0] size);
        logic [4:0] n;
        case (size)
            SIZE_1W:  n = 5'd1;
            SIZE_4W:  n = 5'd4;
            SIZE_8W:  n = 5'd8;
            SIZE_16W: n = 5'd16;
            default:  n = 5'd1;
        endcase
        return n;
    endfunction

    // Index of the final word of a burst, i.e. the value k must reach.
    function automatic logic [3:0] burst_last(input logic [1:0] size);
        logic [4:0] n;
        n = burst_len(size) - 5'd1;
        return n[3:0];
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way grant selection between fetch and data ports.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise data has fixed priority.
module mem_arb_pick
    import mem_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic if_req_i,
    input  logic d_req_i,
    input  logic take_i,
    output logic valid_o,
    output logic grant_o
);

    assign valid_o = if_req_i | d_req_i;

`ifdef MEM_ARB_RR_EN
    logic last_q;
    logic last_d;

    // Tie goes to the port that was not granted most recently.
    always_comb begin
        grant_o = PORT_D;
        last_d  = last_q;
        if (if_req_i && d_req_i) begin
            grant_o = (last_q == PORT_IF) ? PORT_D : PORT_IF;
        end else if (d_req_i) begin
            grant_o = PORT_D;
        end else if (if_req_i) begin
            grant_o = PORT_IF;
        end else begin
            grant_o = PORT_D;
        end
        if (take_i) begin
            last_d = grant_o;
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant register; fetch after reset so data wins the first tie.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= PORT_IF;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_pick_s;

    // Fixed priority: data beats fetch.
    always_comb begin
        grant_o = PORT_D;
        if (d_req_i) begin
            grant_o = PORT_D;
        end else if (if_req_i) begin
            grant_o = PORT_IF;
        end else begin
            grant_o = PORT_D;
        end
    end

    assign unused_pick_s = ^{take_i, clock, reset_n};
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and burst sequencer sharing one memory between fetch and data ports.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: data priority).
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [1:0]        if_size,
    output logic              if_ack,
    output logic              if_rvalid,
    output logic              if_done,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_size,
    input  logic              d_rw,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_rvalid,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic [1:0]        mem_access_size,
    output logic              mem_rw,
    output logic              mem_enable,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [3:0]        k_q, k_d;
    logic [3:0]        last_k_q, last_k_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              rw_q, rw_d;
    logic              en_q, en_d;
    logic              if_ack_q, if_ack_d, d_ack_q, d_ack_d;
    logic              if_rv_q, if_rv_d, d_rv_q, d_rv_d;
    logic              if_done_q, if_done_d, d_done_q, d_done_d;

    logic              grant_s;
    logic              grant_valid_s;
    logic              start_s;
    logic              win_d_s;
    logic              win_write_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [1:0]        win_size_s;
    logic              unused_addr_s;

    mem_arb_pick u_pick (
        .clock    (clock),
        .reset_n  (reset_n),
        .if_req_i (if_req),
        .d_req_i  (d_req),
        .take_i   (start_s),
        .valid_o  (grant_valid_s),
        .grant_o  (grant_s)
    );

    // Request fields of whichever port the picker selected.
    always_comb begin
        win_d_s = (grant_s == PORT_D);
        if (win_d_s) begin
            win_addr_s  = d_addr;
            win_size_s  = d_size;
            win_write_s = d_rw;
        end else begin
            win_addr_s  = if_addr;
            win_size_s  = if_size;
            win_write_s = 1'b0;
        end
    end

    // Next-state and output sequencing; a grant may start from IDLE or LAST.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        k_d       = k_q;
        last_k_d  = last_k_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        rw_d      = rw_q;
        en_d      = en_q;
        if_ack_d  = 1'b0;
        d_ack_d   = 1'b0;
        if_rv_d   = 1'b0;
        d_rv_d    = 1'b0;
        if_done_d = 1'b0;
        d_done_d  = 1'b0;
        start_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start_s = grant_valid_s;
            end
            ST_ISSUE: begin
                if (!mem_busy) begin
                    k_d    = k_q + 4'd1;
                    addr_d = addr_q + WORD_STEP;
                    if (owner_q == PORT_D) begin
                        d_rv_d = ~rw_q;
                    end else begin
                        if_rv_d = ~rw_q;
                    end
                    if (k_q == last_k_q) begin
                        en_d    = 1'b0;
                        rw_d    = 1'b0;
                        state_d = ST_LAST;
                        if (owner_q == PORT_D) begin
                            d_done_d = 1'b1;
                        end else begin
                            if_done_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_LAST: begin
                state_d = ST_IDLE;
                start_s = grant_valid_s;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_s) begin
            state_d = ST_ISSUE;
            owner_d = grant_s;
            addr_d  = {win_addr_s[ADDR_W-1:2], 2'b00};
            k_d     = 4'd0;
            en_d    = 1'b1;
            if (win_write_s) begin
                rw_d     = 1'b1;
                wdata_d  = d_wdata;
                size_d   = SIZE_1W;
                last_k_d = 4'd0;
            end else begin
                rw_d     = 1'b0;
                size_d   = win_size_s;
                last_k_d = burst_last(win_size_s);
            end
            if (win_d_s) begin
                d_ack_d = 1'b1;
            end else begin
                if_ack_d = 1'b1;
            end
        end else begin
            owner_d = owner_q;
        end
    end

    // State and registered outputs; reset abandons any burst and clears all pins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= PORT_IF;
            k_q       <= 4'd0;
            last_k_q  <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= 2'b00;
            rw_q      <= 1'b0;
            en_q      <= 1'b0;
            if_ack_q  <= 1'b0;
            d_ack_q   <= 1'b0;
            if_rv_q   <= 1'b0;
            d_rv_q    <= 1'b0;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            k_q       <= k_d;
            last_k_q  <= last_k_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            rw_q      <= rw_d;
            en_q      <= en_d;
            if_ack_q  <= if_ack_d;
            d_ack_q   <= d_ack_d;
            if_rv_q   <= if_rv_d;
            d_rv_q    <= d_rv_d;
            if_done_q <= if_done_d;
            d_done_q  <= d_done_d;
        end
    end

    assign if_ack          = if_ack_q;
    assign d_ack           = d_ack_q;
    assign if_rvalid       = if_rv_q;
    assign d_rvalid        = d_rv_q;
    assign if_done         = if_done_q;
    assign d_done          = d_done_q;
    assign mem_address     = addr_q;
    assign mem_data_in     = wdata_q;
    assign mem_access_size = size_q;
    assign mem_rw          = rw_q;
    assign mem_enable      = en_q;
    assign rdata           = mem_data_out;

    assign unused_addr_s = ^{if_addr[1:0], d_addr[1:0]};

endmodule
